shared_bus_responder: RTL and testbench

//  Far end of the per-core shared bus: arbitrates shared_request from NUM_CORES cores, returns
//  the one-hot shared_ready grant, and services the granted access.

---
 rtl/shared_bus_responder_pkg.sv | 29 ++
 rtl/shared_bus_responder_dpsram.sv | 39 +++
 rtl/shared_bus_responder_rr_arbiter.sv | 78 +++++++
 rtl/shared_bus_responder.sv | 143 ++++++++++++++
 tb/tb_shared_bus_responder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/shared_bus_responder_pkg.sv
// Shared definitions for the shared-bus responder: address regions,
// device register offsets and small address-decode helpers.
package shared_bus_responder_pkg;

    localparam int BUS_WIDTH = 16;

    // Top two address bits select the region a shared access targets.
    typedef enum logic [1:0] {
        REGION_LOCAL    = 2'b00,
        REGION_GLOBAL   = 2'b01,
        REGION_UNMAPPED = 2'b10,
        REGION_DEVICE   = 2'b11
    } region_e;

    // Device register offsets within the device region (0xC000 base).
    localparam logic [13:0] DEV_NUM_CORES   = 14'd0;
    localparam logic [13:0] DEV_CYCLE_COUNT = 14'd1;
    localparam logic [13:0] DEV_SEMAPHORE   = 14'd2;

    function automatic region_e addr_region(input logic [15:0] addr);
        return region_e'(addr[15:14]);
    endfunction

    // True only for the exact device register address, not its aliases.
    function automatic logic is_dev_reg(input logic [15:0] addr, input logic [13:0] offset);
        return (addr[15:14] == REGION_DEVICE) && (addr[13:0] == offset);
    endfunction

endpackage

// File: rtl/shared_bus_responder_dpsram.sv
// Dual-port synchronous RAM, read-first on each port. Contents are not
// reset so that data survives a bus reset.
module dpsram #(
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Both ports share one process so the array has a single driver.
    always_ff @(posedge clk) begin
        if (a_en) begin
            if (a_we) begin
                mem_r[a_addr] <= a_wdata;
            end
            a_rdata <= mem_r[a_addr];
        end
        if (b_en) begin
            if (b_we) begin
                mem_r[b_addr] <= b_wdata;
            end
            b_rdata <= mem_r[b_addr];
        end
    end

endmodule

// File: rtl/shared_bus_responder_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant to the first requester
// at or after rr_ptr (modulo NUM_CORES); rr_ptr advances past each winner.
module rr_arbiter #(
    parameter int NUM_CORES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_CORES-1:0] request,
    output logic [NUM_CORES-1:0] grant
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [PTR_W-1:0] rr_ptr_r;
    logic [PTR_W-1:0] rr_ptr_next_s;
    logic             grant_any_s;
    int               ptr_int_s;
    int               dist_s;
    int               best_dist_s;
    int               best_idx_s;

    assign ptr_int_s = int'(rr_ptr_r);

    // Pick the requester with the smallest circular distance from rr_ptr.
    always_comb begin
        dist_s      = 32'sd0;
        best_dist_s = NUM_CORES;
        best_idx_s  = 32'sd0;
        grant_any_s = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (request[i]) begin
                if (i >= ptr_int_s) begin
                    dist_s = i - ptr_int_s;
                end else begin
                    dist_s = i + NUM_CORES - ptr_int_s;
                end
                if (dist_s < best_dist_s) begin
                    best_dist_s = dist_s;
                    best_idx_s  = i;
                    grant_any_s = 1'b1;
                end else begin
                    grant_any_s = grant_any_s;
                end
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Expand the winner to a one-hot grant (forced low in reset) and compute the next pointer.
    always_comb begin
        grant = {NUM_CORES{1'b0}};
        for (int i = 0; i < NUM_CORES; i++) begin
            if (reset_n && grant_any_s && (best_idx_s == i)) begin
                grant[i] = 1'b1;
            end else begin
                grant[i] = 1'b0;
            end
        end
        if (best_idx_s == NUM_CORES - 1) begin
            rr_ptr_next_s = {PTR_W{1'b0}};
        end else begin
            rr_ptr_next_s = PTR_W'(best_idx_s + 32'sd1);
        end
    end

    // Pointer moves only on granted cycles so idle time does not shift priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= {PTR_W{1'b0}};
        end else if (grant_any_s) begin
            rr_ptr_r <= rr_ptr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/shared_bus_responder.sv
// Far end of the per-core shared bus: arbitrates core requests, returns the
// one-hot grant and services one global-RAM or device-register access per grant.
module shared_bus_responder
    import shared_bus_responder_pkg::*;
#(
    parameter int NUM_CORES          = 4,
    parameter int GLOBAL_MEMORY_SIZE = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_CORES-1:0] core_request,
    output logic [NUM_CORES-1:0] core_ready,
    input  logic [15:0]          bus_addr,
    input  logic                 bus_wren,
    input  logic                 bus_rden,
    input  logic [15:0]          bus_write_val,
    output logic [15:0]          bus_read_val
);

    localparam int GLOBAL_ADDR_WIDTH = $clog2(GLOBAL_MEMORY_SIZE);

    logic                         grant_any_s;
    region_e                      region_s;
    logic                         is_global_s;
    logic                         wr_commit_s;
    logic                         rd_commit_s;
    logic                         ram_en_s;
    logic                         ram_we_s;
    logic [GLOBAL_ADDR_WIDTH-1:0] ram_idx_s;
    logic [15:0]                  ram_q_s;
    logic [15:0]                  port_a_unused_s;
    logic [15:0]                  rd_mux_s;
    logic [15:0]                  cycle_cnt_r;
    logic                         sem_r;
    logic [15:0]                  rd_hold_r;
    logic                         rd_from_ram_r;

    rr_arbiter #(
        .NUM_CORES(NUM_CORES)
    ) u_arbiter (
        .clk     (clk),
        .reset_n (reset_n),
        .request (core_request),
        .grant   (core_ready)
    );

    // The bus only carries meaningful values while some core holds a grant.
    assign grant_any_s = |core_ready;
    assign region_s    = addr_region(bus_addr);
    assign is_global_s = (region_s == REGION_GLOBAL);
    assign wr_commit_s = grant_any_s & bus_wren;
    assign rd_commit_s = grant_any_s & bus_rden;
    assign ram_idx_s   = bus_addr[GLOBAL_ADDR_WIDTH-1:0];
    assign ram_en_s    = grant_any_s & is_global_s & (bus_wren | bus_rden);
    assign ram_we_s    = wr_commit_s & is_global_s;

    dpsram #(
        .DEPTH      (GLOBAL_MEMORY_SIZE),
        .ADDR_WIDTH (GLOBAL_ADDR_WIDTH),
        .DATA_WIDTH (BUS_WIDTH)
    ) u_global_ram (
        .clk     (clk),
        .a_en    (1'b0),
        .a_we    (1'b0),
        .a_addr  ({GLOBAL_ADDR_WIDTH{1'b0}}),
        .a_wdata (16'h0000),
        .a_rdata (port_a_unused_s),
        .b_en    (ram_en_s),
        .b_we    (ram_we_s),
        .b_addr  (ram_idx_s),
        .b_wdata (bus_write_val),
        .b_rdata (ram_q_s)
    );

    // Read data for every non-RAM target; unmapped and stray device addresses read zero.
    always_comb begin
        rd_mux_s = 16'h0000;
        case (region_s)
            REGION_DEVICE: begin
                if (is_dev_reg(bus_addr, DEV_NUM_CORES)) begin
                    rd_mux_s = 16'(NUM_CORES);
                end else if (is_dev_reg(bus_addr, DEV_CYCLE_COUNT)) begin
                    rd_mux_s = cycle_cnt_r;
                end else if (is_dev_reg(bus_addr, DEV_SEMAPHORE)) begin
                    rd_mux_s = {15'h0000, sem_r};
                end else begin
                    rd_mux_s = 16'h0000;
                end
            end
            default: rd_mux_s = 16'h0000;
        endcase
    end

    // Free-running cycle counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_r <= 16'h0000;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 16'h0001;
        end
    end

    // Test-and-set semaphore: a read sets it, a write clears it; a write beats a simultaneous read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sem_r <= 1'b0;
        end else if (wr_commit_s && is_dev_reg(bus_addr, DEV_SEMAPHORE)) begin
            sem_r <= 1'b0;
        end else if (rd_commit_s && is_dev_reg(bus_addr, DEV_SEMAPHORE)) begin
            sem_r <= 1'b1;
        end else begin
            sem_r <= sem_r;
        end
    end

    // Capture read results. A write-only RAM access would disturb the RAM's
    // output register, so the last RAM read data is moved into rd_hold_r first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_hold_r     <= 16'h0000;
            rd_from_ram_r <= 1'b0;
        end else if (rd_commit_s) begin
            rd_hold_r     <= rd_mux_s;
            rd_from_ram_r <= is_global_s;
        end else if (ram_en_s && rd_from_ram_r) begin
            rd_hold_r     <= ram_q_s;
            rd_from_ram_r <= 1'b0;
        end else begin
            rd_hold_r     <= rd_hold_r;
            rd_from_ram_r <= rd_from_ram_r;
        end
    end

    // Broadcast read value: RAM data comes straight from the RAM output register.
    always_comb begin
        if (rd_from_ram_r) begin
            bus_read_val = ram_q_s;
        end else begin
            bus_read_val = rd_hold_r;
        end
    end

endmodule

// File: tb/tb_shared_bus_responder.sv
// Scoreboard bench for shared_bus_responder: the driver issues one cycle of
// requests/bus traffic, a reference model predicts grant and read data into
// queues, and a monitor on the falling edge compares the DUT against them.
module tb_shared_bus_responder;

    localparam int N = 4;

    typedef struct {
        logic        valid;
        logic [15:0] data;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  core_request;
    logic [N-1:0]  core_ready;
    logic [15:0]   bus_addr;
    logic          bus_wren;
    logic          bus_rden;
    logic [15:0]   bus_write_val;
    logic [15:0]   bus_read_val;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0] ram_m [int];
    int          ptr_m = 0;
    logic        sem_m = 1'b0;
    logic [15:0] cc_m;

    logic [N-1:0] gq [$];
    rd_exp_t      rq [$];
    logic [15:0]  exp_rd = 16'h0000;
    logic         exp_rd_valid = 1'b1;
    logic         mon_en = 1'b0;

    always #5 clk = ~clk;

    shared_bus_responder #(
        .NUM_CORES          (N),
        .GLOBAL_MEMORY_SIZE (4096)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .core_request  (core_request),
        .core_ready    (core_ready),
        .bus_addr      (bus_addr),
        .bus_wren      (bus_wren),
        .bus_rden      (bus_rden),
        .bus_write_val (bus_write_val),
        .bus_read_val  (bus_read_val)
    );

    // Number of rising edges seen since reset release: the value the cycle counter should show.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cc_m <= 16'h0000;
        else          cc_m <= cc_m + 16'h0001;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One bus cycle: req is the request vector, the op belongs to whichever core wins.
    task automatic drive_cycle(input logic [N-1:0] req, input logic [15:0] addr,
                               input logic wr, input logic rd, input logic [15:0] wdat);
        int      g;
        int      r;
        int      idx;
        rd_exp_t e;
        g = -1;
        r = int'(req);
        for (int k = 0; k < N; k++) begin
            if (g < 0 && (((r >> ((ptr_m + k) % N)) & 1) != 0)) g = (ptr_m + k) % N;
        end
        gq.push_back((g >= 0) ? N'(1 << g) : N'(0));
        core_request = req;
        if (g >= 0) begin
            ptr_m = (g + 1) % N;
            bus_addr = addr; bus_wren = wr; bus_rden = rd; bus_write_val = wdat;
            idx = int'(addr[11:0]);
            if (rd) begin
                e.valid = 1'b1;
                e.data  = 16'h0000;
                if (addr[15:14] == 2'b01) begin
                    if (ram_m.exists(idx)) e.data = ram_m[idx];
                    else e.valid = 1'b0;
                end else if (addr == 16'hC000) e.data = 16'(N);
                else if (addr == 16'hC001) e.data = cc_m;
                else if (addr == 16'hC002) e.data = {15'h0000, sem_m};
                rq.push_back(e);
                if (addr == 16'hC002) sem_m = 1'b1;
            end
            if (wr) begin
                if (addr[15:14] == 2'b01) ram_m[idx] = wdat;
                else if (addr == 16'hC002) sem_m = 1'b0;
            end
        end else begin
            bus_addr = 16'hxxxx; bus_wren = 1'bx; bus_rden = 1'bx; bus_write_val = 16'hxxxx;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare grant every cycle and the held read value against the scoreboard.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_rd       <= 16'h0000;
            exp_rd_valid <= 1'b1;
        end else if (mon_en) begin
            if (gq.size() > 0) check("grant", 32'(core_ready), 32'(gq.pop_front()));
            if (exp_rd_valid) check("read_val", 32'(bus_read_val), 32'(exp_rd));
            if (rq.size() > 0) begin
                exp_rd       <= rq[0].data;
                exp_rd_valid <= rq[0].valid;
                void'(rq.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] a;
        int op;
        reset_n = 1'b0;
        core_request = '0;
        bus_addr = 16'h0000; bus_wren = 1'b0; bus_rden = 1'b0; bus_write_val = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(core_ready), 32'h0);
        check("reset_read_val", 32'(bus_read_val), 32'h0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // All cores request continuously: 0,1,2,3,0,...
        for (int i = 0; i < 8; i++) drive_cycle(4'b1111, 16'hC000, 1'b0, 1'b1, 16'h0000);
        // Single core write then read of global RAM
        drive_cycle(4'b0001, 16'h4010, 1'b1, 1'b0, 16'hBEEF);
        drive_cycle(4'b0001, 16'h4010, 1'b0, 1'b1, 16'h0000);
        drive_cycle(4'b0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        // Put rr_ptr at 2, then cores 0 and 3 compete: 3 first, then 0
        drive_cycle(4'b0010, 16'h0000, 1'b0, 1'b0, 16'h0000);
        drive_cycle(4'b1001, 16'hC000, 1'b0, 1'b1, 16'h0000);
        drive_cycle(4'b1001, 16'hC000, 1'b0, 1'b1, 16'h0000);
        // Semaphore test-and-set and release
        drive_cycle(4'b0010, 16'hC002, 1'b0, 1'b1, 16'h0000);
        drive_cycle(4'b0100, 16'hC002, 1'b0, 1'b1, 16'h0000);
        drive_cycle(4'b0010, 16'hC002, 1'b1, 1'b0, 16'h0000);
        drive_cycle(4'b0100, 16'hC002, 1'b0, 1'b1, 16'h0000);
        // Device registers, unmapped region, cycle count five cycles apart
        drive_cycle(4'b0001, 16'hC000, 1'b0, 1'b1, 16'h0000);
        drive_cycle(4'b0001, 16'h8123, 1'b0, 1'b1, 16'h0000);
        drive_cycle(4'b0001, 16'hC001, 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 4; i++) drive_cycle(4'b0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        drive_cycle(4'b0001, 16'hC001, 1'b0, 1'b1, 16'h0000);
        // Write and read in the same grant returns the old data
        drive_cycle(4'b0001, 16'h4010, 1'b1, 1'b1, 16'h1111);
        drive_cycle(4'b0001, 16'h4010, 1'b0, 1'b1, 16'h0000);

        // Reset in the middle of a read grant
        drive_cycle(4'b0001, 16'h4020, 1'b1, 1'b0, 16'h1234);
        drive_cycle(4'b0001, 16'h4020, 1'b0, 1'b1, 16'h0000);
        mon_en = 1'b0;
        core_request = 4'b0001; bus_addr = 16'h4010; bus_rden = 1'b1; bus_wren = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_ready", 32'(core_ready), 32'h0);
        check("midreset_read_val", 32'(bus_read_val), 32'h0);
        gq.delete();
        rq.delete();
        ptr_m = 0;
        sem_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        core_request = '0;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        drive_cycle(4'b0001, 16'h4020, 1'b0, 1'b1, 16'h0000);
        drive_cycle(4'b0010, 16'h5010, 1'b0, 1'b1, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = {2'b01, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 7))};
                5:             a = 16'hC000;
                6:             a = 16'hC001;
                7:             a = 16'hC002;
                8:             a = {2'b11, 14'($urandom)};
                default:       a = {1'b0 ^ 1'($urandom_range(0, 1)), 1'b0, 14'($urandom)};
            endcase
            op = $urandom_range(0, 3);
            drive_cycle(($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)),
                        a, op[1], op[0], 16'($urandom));
        end
        drive_cycle(4'b0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        drive_cycle(4'b0000, 16'h0000, 1'b0, 1'b0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
